// File: rtl/lsu_pkg.sv
// lsu_pkg: shared FSM state, access-size encodings and misalignment rule for the load/store unit
package lsu_pkg;
  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    return (size == SZ_HALF && off[0]) || (size == SZ_WORD && off != 2'b00) || size == 2'b11;
  endfunction
endpackage

// File: rtl/lsu_if.sv
// lsu_if: core-side request/response channel of the load/store unit
interface lsu_if #(parameter int AW = 32, parameter int DW = 32);
  logic          req;
  logic          req_we;
  logic [1:0]    req_size;
  logic          req_signed;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          busy;
  logic          done;
  logic [DW-1:0] rdata;
  logic          misaligned;
  modport master (output req, req_we, req_size, req_signed, req_addr, req_wdata,
                  input busy, done, rdata, misaligned);
  modport slave (input req, req_we, req_size, req_signed, req_addr, req_wdata,
                 output busy, done, rdata, misaligned);
endinterface

// File: rtl/lsu_lane_merge.sv
// lsu_lane_merge: big-endian lane extract/extend for loads and lane replace for sub-word stores
module lsu_lane_merge
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic        sgn,
  input  logic [31:0] wdata,
  output logic [31:0] load_val,
  output logic [31:0] store_val
);
  logic [4:0]  sh_b;
  logic [4:0]  sh_h;
  logic [7:0]  b;
  logic [15:0] h;
  assign sh_b = {~off, 3'b000};
  assign sh_h = {~off[1], 4'b0000};
  assign b = 8'(word >> sh_b);
  assign h = 16'(word >> sh_h);
  assign load_val = size == SZ_BYTE ? {{24{sgn & b[7]}}, b} :
                    size == SZ_HALF ? {{16{sgn & h[15]}}, h} : word;
  assign store_val = size == SZ_BYTE ? (word & ~(32'h0000_00ff << sh_b)) | ({24'b0, wdata[7:0]} << sh_b) :
                     size == SZ_HALF ? (word & ~(32'h0000_ffff << sh_h)) | ({16'b0, wdata[15:0]} << sh_h) :
                     wdata;
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store FSM with sub-word read-modify-write; LSU_MISALIGN_TRAP_EN rejects misaligned accesses instead of force-aligning
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  lsu_if.slave          bus,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);
  state_t        state;
  logic          l_we;
  logic [1:0]    l_size;
  logic          l_signed;
  logic [AW-1:0] l_addr;
  logic [DW-1:0] l_wdata;
  logic [DW-1:0] word_q;
  logic [DW-1:0] rdata_q;
  logic          mis_q;
  logic [1:0]    a_size;
  logic [AW-1:0] a_addr;
  logic          a_mis;
  logic [31:0]   load_val;
  logic [31:0]   store_val;
`ifdef LSU_MISALIGN_TRAP_EN
  assign a_size = bus.req_size;
  assign a_addr = bus.req_addr;
  assign a_mis  = is_misaligned(bus.req_size, bus.req_addr[1:0]);
`else
  assign a_size = bus.req_size == SZ_BYTE ? SZ_BYTE : bus.req_size == SZ_HALF ? SZ_HALF : SZ_WORD;
  assign a_addr = a_size == SZ_BYTE ? bus.req_addr :
                  a_size == SZ_HALF ? {bus.req_addr[AW-1:1], 1'b0} : {bus.req_addr[AW-1:2], 2'b00};
  assign a_mis  = 1'b0;
`endif
  lsu_lane_merge u_merge (
    .word      (state == RD ? ram_dout : word_q),
    .size      (l_size),
    .off       (l_addr[1:0]),
    .sgn       (l_signed),
    .wdata     (l_wdata),
    .load_val  (load_val),
    .store_val (store_val)
  );
  // Accept, sequence and complete one access at a time; reset aborts anything in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      l_we     <= 1'b0;
      l_size   <= 2'b00;
      l_signed <= 1'b0;
      l_addr   <= '0;
      l_wdata  <= '0;
      word_q   <= '0;
      rdata_q  <= '0;
      mis_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.req) begin
          l_we     <= bus.req_we;
          l_size   <= a_size;
          l_signed <= bus.req_signed;
          l_addr   <= a_addr;
          l_wdata  <= bus.req_wdata;
          mis_q    <= a_mis;
          state    <= a_mis ? RESP : (bus.req_we && a_size == SZ_WORD) ? WR : RD;
        end
        RD: begin
          word_q <= ram_dout;
          if (!l_we) rdata_q <= load_val;
          state <= l_we ? WR : RESP;
        end
        WR:      state <= RESP;
        default: state <= IDLE;
      endcase
    end
  end
  assign ram_we     = state == WR && rst_n;
  assign ram_addr   = (state == RD || state == WR) ? {l_addr[AW-1:2], 2'b00} : '0;
  assign ram_din    = store_val;
  assign bus.busy   = state != IDLE;
  assign bus.done   = state == RESP;
  assign bus.rdata  = rdata_q;
  assign bus.misaligned = mis_q && state == RESP;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: table-driven scoreboard bench for load_store_unit plus reset/hold/back-to-back sequences
module tb_load_store_unit;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  typedef struct {
    bit          pre;
    logic [31:0] paddr;
    logic [31:0] pdata;
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] e_rdata;
    logic        e_mis;
    int          e_lat;
    int          e_we;
    logic [31:0] e_mem;
  } vec_t;
  typedef struct {
    logic [31:0] rdata;
    logic        mis;
    int          lat;
    int          we;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;
  logic [31:0] mem [0:255];
  logic        pre_we = 1'b0;
  logic [31:0] pre_addr = '0;
  logic [31:0] pre_data = '0;
  int          n_vec = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  exp_t        sb[$];
  vec_t        tbl[12];

  always #5 clk = ~clk;

  lsu_if #(.AW(32), .DW(32)) bus ();

  load_store_unit #(.AW(32), .DW(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_dout (ram_dout)
  );

  assign ram_dout = mem[ram_addr[9:2]];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr[9:2]] <= ram_din;
    else if (pre_we) mem[pre_addr[9:2]] <= pre_data;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_we = 1'b1;
    pre_addr = a;
    pre_data = d;
    @(posedge clk);
    #1 pre_we = 1'b0;
  endtask

  task automatic run(input vec_t v, input bit hold, input string tag);
    exp_t e;
    int k;
    int wec;
    bit seen;
    if (v.pre) preload(v.paddr, v.pdata);
    sb.push_back('{rdata: v.e_rdata, mis: v.e_mis, lat: v.e_lat, we: v.e_we});
    @(negedge clk);
    bus.req = 1'b1;
    bus.req_we = v.we;
    bus.req_size = v.size;
    bus.req_signed = v.sgn;
    bus.req_addr = v.addr;
    bus.req_wdata = v.wdata;
    @(posedge clk);
    #1 if (!hold) bus.req = 1'b0;
    k = 1;
    wec = 0;
    seen = 1'b0;
    while (!seen && k <= 8) begin
      wec += int'(ram_we);
      if (bus.done) seen = 1'b1;
      else begin
        @(posedge clk);
        #1 k++;
      end
    end
    bus.req = 1'b0;
    e = sb.pop_front();
    chk({tag, " latency"}, seen ? k : 0, e.lat);
    chk({tag, " ram_we cycles"}, wec, e.we);
    chk({tag, " rdata"}, bus.rdata, e.rdata);
    chk({tag, " misaligned"}, {31'b0, bus.misaligned}, {31'b0, e.mis});
    chk({tag, " mem word"}, mem[v.paddr[9:2]], v.e_mem);
    @(posedge clk);
    #1 chk({tag, " done one cycle"}, {31'b0, bus.done}, 32'd0);
    n_vec++;
  endtask

  initial begin
    int cnt;
    vec_t v;
    bus.req = 1'b0;
    bus.req_we = 1'b0;
    bus.req_size = 2'b00;
    bus.req_signed = 1'b0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    tbl[0]  = '{1, 32'h40, 32'h8899AABB, 0, 2'b00, 1, 32'h41, 32'h0, 32'hFFFFFF99, 0, 2, 0, 32'h8899AABB};
    tbl[1]  = '{0, 32'h40, 32'h0, 0, 2'b01, 0, 32'h42, 32'h0, 32'h0000AABB, 0, 2, 0, 32'h8899AABB};
    tbl[2]  = '{0, 32'h40, 32'h0, 0, 2'b10, 0, 32'h40, 32'h0, 32'h8899AABB, 0, 2, 0, 32'h8899AABB};
    tbl[3]  = '{0, 32'h40, 32'h0, 0, 2'b00, 0, 32'h40, 32'h0, 32'h00000088, 0, 2, 0, 32'h8899AABB};
    tbl[4]  = '{0, 32'h40, 32'h0, 0, 2'b01, 1, 32'h40, 32'h0, 32'hFFFF8899, 0, 2, 0, 32'h8899AABB};
    tbl[5]  = '{0, 32'h40, 32'h0, 0, 2'b00, 1, 32'h43, 32'h0, 32'hFFFFFFBB, 0, 2, 0, 32'h8899AABB};
    tbl[6]  = '{1, 32'h40, 32'h11223344, 1, 2'b00, 0, 32'h42, 32'h000000EE, 32'hFFFFFFBB, 0, 3, 1, 32'h1122EE44};
    tbl[7]  = '{0, 32'h40, 32'h0, 1, 2'b01, 0, 32'h40, 32'h1234ABCD, 32'hFFFFFFBB, 0, 3, 1, 32'hABCDEE44};
    tbl[8]  = '{0, 32'h44, 32'h0, 1, 2'b10, 0, 32'h44, 32'hDEADBEEF, 32'hFFFFFFBB, 0, 2, 1, 32'hDEADBEEF};
    tbl[9]  = '{0, 32'h44, 32'h0, 1, 2'b10, 0, 32'h46, 32'hCAFEF00D, 32'hFFFFFFBB,
                TRAP, TRAP ? 1 : 2, TRAP ? 0 : 1, TRAP ? 32'hDEADBEEF : 32'hCAFEF00D};
    tbl[10] = '{0, 32'h44, 32'h0, 0, 2'b01, 0, 32'h45, 32'h0, TRAP ? 32'hFFFFFFBB : 32'h0000CAFE,
                TRAP, TRAP ? 1 : 2, 0, TRAP ? 32'hDEADBEEF : 32'hCAFEF00D};
    tbl[11] = '{0, 32'h40, 32'h0, 0, 2'b11, 0, 32'h41, 32'h0, TRAP ? 32'hFFFFFFBB : 32'hABCDEE44,
                TRAP, TRAP ? 1 : 2, 0, 32'hABCDEE44};
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", {31'b0, bus.busy}, 32'd0);
    chk("reset done", {31'b0, bus.done}, 32'd0);
    chk("reset misaligned", {31'b0, bus.misaligned}, 32'd0);
    chk("reset ram_we", {31'b0, ram_we}, 32'd0);
    chk("reset rdata", bus.rdata, 32'd0);
    chk("reset ram_addr", ram_addr, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 12; i++) run(tbl[i], 1'b0, $sformatf("vec%0d", i));
    // reset asserted during the WR cycle of a byte store
    preload(32'h50, 32'h01020304);
    @(negedge clk);
    bus.req = 1'b1;
    bus.req_we = 1'b1;
    bus.req_size = 2'b00;
    bus.req_addr = 32'h51;
    bus.req_wdata = 32'h77;
    @(posedge clk);
    #1 bus.req = 1'b0;
    chk("rst_wr RD busy", {31'b0, bus.busy}, 32'd1);
    @(posedge clk);
    #1 chk("rst_wr WR ram_we", {31'b0, ram_we}, 32'd1);
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_wr busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_wr mem", mem[32'h50 >> 2], 32'h01020304);
    chk("rst_wr rdata", bus.rdata, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1 cnt += int'(bus.done) + int'(ram_we);
    end
    chk("rst_wr no done/write", cnt, 0);
    n_vec++;
    // req held high through the whole access
    v = '{0, 32'h40, 32'h0, 0, 2'b10, 0, 32'h40, 32'h0, 32'hABCDEE44, 0, 2, 0, 32'hABCDEE44};
    run(v, 1'b1, "hold");
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1 cnt += int'(bus.busy);
    end
    chk("hold single access", cnt, 0);
    // store then load issued the cycle after done
    v = '{0, 32'h60, 32'h0, 1, 2'b10, 0, 32'h60, 32'h000000A5, 32'hABCDEE44, 0, 2, 1, 32'h000000A5};
    run(v, 1'b0, "b2b store");
    v = '{0, 32'h60, 32'h0, 0, 2'b00, 0, 32'h63, 32'h0, 32'h000000A5, 0, 2, 0, 32'h000000A5};
    run(v, 1'b0, "b2b load");
    chk("scoreboard empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter AW, default 32, SHALL set the byte-address width.
REQ-002 Parameter DW, default 32, SHALL set the data word width; only 32 is supported.
REQ-003 Port clk  in  1  SHALL be the single clock; all state updates on rising edge.
REQ-004 Port rst_n  in  1  SHALL be the reset: synchronous, active-low.
REQ-005 Port req  in  1  SHALL request an access; sampled only while busy=0.
REQ-006 Port req_we  in  1  SHALL select store (1) or load (0).
REQ-007 Port req_size  in  2  SHALL encode access size: 00 byte, 01 half, 10 word, 11 illegal.
REQ-008 Port req_signed  in  1  SHALL select sign extension (1) or zero extension (0) for loads.
REQ-009 Port req_addr  in  AW  SHALL carry the byte address.
REQ-010 Port req_wdata  in  DW  SHALL carry store data, right-justified.
REQ-011 Port busy  out  1  SHALL be high whenever state != IDLE; this is the core stall.
REQ-012 Port done  out  1  SHALL pulse for exactly one cycle on completion.
REQ-013 Port rdata  out  DW  SHALL carry the extended load result, held until the next load completes.
REQ-014 Port misaligned  out  1  SHALL be valid with done; high when an access is rejected.
REQ-015 Ports ram_we out 1, ram_addr out AW, ram_din out DW and ram_dout in DW SHALL connect to the word-wide data RAM.
  - RAM behaviour: combinational read, write on posedge, word index = addr[AW-1:2].

Function
REQ-016 The FSM SHALL have the states IDLE, RD, WR and RESP.
REQ-017 In IDLE with req=1, the unit SHALL latch all req_* fields and transition at that edge (acceptance edge N).
REQ-018 Transitions SHALL be:
  - Load: IDLE->RD->RESP.
  - Word store: IDLE->WR->RESP.
  - Byte/half store: IDLE->RD->WR->RESP (read-modify-write).
  - Rejected access: IDLE->RESP.
  - RESP always returns to IDLE.
REQ-019 done SHALL be high exactly when state=RESP.
  - Latency after edge N: load 2 cycles, word store 2 cycles, sub-word store 3 cycles, rejected access 1 cycle.
REQ-020 ram_addr SHALL equal {latched_addr[AW-1:2], 2'b00} in RD and WR, and 0 otherwise.
REQ-021 ram_we SHALL be high only in WR.
REQ-022 In RD, the unit SHALL capture ram_dout into an internal word register at the RD exit edge.
REQ-023 Byte lanes SHALL be big-endian: byte offset 0 = bits 31:24, offset 3 = bits 7:0; half offset 0 = bits 31:16.
REQ-024 Loads SHALL extract the addressed lane from the captured word and sign- or zero-extend it to DW into rdata at the RD exit edge.
REQ-025 Sub-word stores SHALL drive ram_din = captured word with only the addressed lane replaced by req_wdata[7:0] or [15:0].
REQ-026 Word stores SHALL drive ram_din = latched wdata.
REQ-027 An access SHALL be misaligned when any of these holds:
  - half with addr[0]=1;
  - word with addr[1:0]!=0;
  - req_size=11.
REQ-028 req while busy=1 SHALL be ignored, including during the RESP cycle; no queuing.
REQ-029 A rejected access SHALL NOT assert ram_we and SHALL leave rdata unchanged.

Reset
REQ-030 While rst_n=0 at a clock edge, the unit SHALL reset to:
  - state=IDLE;
  - rdata=0, captured word=0, all latched fields=0;
  - busy=0, done=0, misaligned=0, ram_we=0.
REQ-031 Reset asserted mid-operation (RD or WR) SHALL abort the access with no pending write issued afterwards and no done pulse.

Configuration
REQ-032 With macro LSU_MISALIGN_TRAP_EN defined, misaligned accesses SHALL be rejected per REQ-027 and REQ-029, with misaligned=1.
REQ-033 Without LSU_MISALIGN_TRAP_EN:
  - the address SHALL be force-aligned (half clears addr[0]; word clears addr[1:0]);
  - the access SHALL proceed normally;
  - misaligned SHALL be tied 0;
  - req_size=11 SHALL be treated as word.

Structure
REQ-034 Package lsu_pkg SHALL hold:
  - the state enum (IDLE/RD/WR/RESP);
  - size constants SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - a function computing the misaligned condition.
REQ-035 Sub-module lsu_lane_merge (purely combinational) SHALL perform lane extraction/extension for loads and lane merge for stores; the FSM and registers SHALL stay in load_store_unit.

Verification
REQ-036 Preload word 0x40 = 0x8899AABB; load byte signed at 0x41 -> done at N+2, rdata=0xFFFFFF99, misaligned=0, ram_we never high.
REQ-037 Same word; load half unsigned at 0x42 -> rdata=0x0000AABB; load word at 0x40 -> rdata=0x8899AABB.
REQ-038 Preload word 0x40 = 0x11223344; store byte 0xEE at 0x42 -> RD, WR, RESP sequence, ram_we high for exactly 1 cycle, word 0x40 = 0x1122EE44, done at N+3.
REQ-039 With LSU_MISALIGN_TRAP_EN, store word at 0x46 -> done at N+1 with misaligned=1, no RAM write, rdata unchanged; without the macro, the same store writes word 0x44.
REQ-040 Reset, concurrency and back-to-back checks SHALL all pass:
  - rst_n=0 during WR of a byte store -> no write, state IDLE, done stays 0.
  - req held high during busy -> exactly one access performed.
  - Back-to-back requests issued on the cycle after done -> both complete.
